// File: rtl/int_vector_ctrl_if.sv
// -----------------------------------------------------------------------------
// int_vector_ctrl_if
// Shared RAM port used by the interrupt controller to fetch handler addresses
// from the vector table.
//   ram_add_bus        byte address of the vector entry
//   ram_size           access size (3 = word)
//   ram_rw             00 idle, 10 read
//   ram_data_bus_read  read data returned by the RAM
//   isCplt             RAM completion strobe
//   get_ram_ask        controller requests ownership of the RAM port
// Modports: master = interrupt controller, slave = RAM / arbiter side.
// -----------------------------------------------------------------------------
interface int_vector_ctrl_if;
    logic [31:0] ram_add_bus;
    logic [1:0]  ram_size;
    logic [1:0]  ram_rw;
    logic [31:0] ram_data_bus_read;
    logic        isCplt;
    logic        get_ram_ask;

    modport master (
        output ram_add_bus, ram_size, ram_rw, get_ram_ask,
        input  ram_data_bus_read, isCplt
    );

    modport slave (
        input  ram_add_bus, ram_size, ram_rw, get_ram_ask,
        output ram_data_bus_read, isCplt
    );
endinterface

// File: rtl/int_vector_ctrl.sv
// -----------------------------------------------------------------------------
// int_vector_ctrl
// Multi-source interrupt controller. Latches rising edges on N_EXT external
// lines plus one level-sensitive internal request, picks one by fixed priority
// (external lowest index first, then internal), freezes the pipeline, saves the
// resume address, reads the handler address from the vector table over the
// shared RAM port (with timeout fallback) and writes it to pc.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ext_req, ext_mask       external request lines / per-line enables
//   int_sign_internal,
//   int_num_internal        internal (exception) request and its number
//   sys                     status register, sys[0] = global enable
//   p1..p4_add, pc, p*_run  pipeline addresses and stage valid flags
//   la_ta_ask, clean_ask    privilege/ipc write request, pipeline flush
//   ipc_w, pc_w, pc_we      resume address, handler address, pc write strobe
//   pending, active_num     latched external requests, serviced number
//   vec_fault               one-cycle pulse when the vector fetch timed out
//   ram                     shared RAM port (master side)
// -----------------------------------------------------------------------------
module int_vector_ctrl #(
    parameter int          N_EXT        = 8,
    parameter logic [7:0]  EXT_NUM_BASE = 8'h10,
    parameter logic [31:0] VEC_BASE     = 32'h0000_0000,
    parameter int          TIMEOUT      = 16,
    parameter logic [31:0] FAULT_PC     = 32'h0000_0004
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_EXT-1:0]  ext_req,
    input  logic [N_EXT-1:0]  ext_mask,
    input  logic              int_sign_internal,
    input  logic [7:0]        int_num_internal,
    input  logic [31:0]       sys,
    input  logic [31:0]       p1_add,
    input  logic [31:0]       p2_add,
    input  logic [31:0]       p3_add,
    input  logic [31:0]       p4_add,
    input  logic [31:0]       pc,
    input  logic              p1_run,
    input  logic              p2_run,
    input  logic              p3_run,
    output logic              la_ta_ask,
    output logic              clean_ask,
    output logic [31:0]       ipc_w,
    output logic [31:0]       pc_w,
    output logic              pc_we,
    output logic [N_EXT-1:0]  pending,
    output logic [7:0]        active_num,
    output logic              vec_fault,
    int_vector_ctrl_if.master ram
);

    localparam int IDX_W = (N_EXT > 1) ? $clog2(N_EXT) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD
    } state_t;

    state_t             state, next_state;
    logic [N_EXT-1:0]   ext_req_q;
    logic [TMR_W-1:0]   timer;

    logic [N_EXT-1:0]   eligible;
    logic               ext_any;
    logic               trig;
    logic [IDX_W-1:0]   win_idx;
    logic [7:0]         sel_num;
    logic [31:0]        resume_add;
    logic [N_EXT-1:0]   accept_clr;
    logic               timed_out;

    // Only the global-enable bit of the status register matters here.
    logic unused_sys;
    assign unused_sys = ^sys[31:1];

    assign eligible = pending & ext_mask;
    assign ext_any  = |eligible;
    assign trig     = sys[0] & (int_sign_internal | ext_any);

    // Scanning downward makes the lowest set index the last (winning) write.
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        win_idx = '0;
        for (int i = N_EXT - 1; i >= 0; i--) begin
            if (eligible[i]) win_idx = IDX_W'(i);
        end
    end

    assign sel_num = ext_any ? (EXT_NUM_BASE + 8'(win_idx)) : int_num_internal;

    // With both sources present the external one is taken, so the faulting
    // instruction in stage 4 must re-execute after the handler returns.
    always_comb begin
        if (ext_any && int_sign_internal) resume_add = p4_add;
        else if (p3_run)                  resume_add = p3_add;
        else if (p2_run)                  resume_add = p2_add;
        else if (p1_run)                  resume_add = p1_add;
        else                              resume_add = pc;
    end

    assign accept_clr = (state == IDLE && trig && ext_any)
                      ? (N_EXT'(1) << win_idx) : '0;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        la_ta_ask  = 1'b0;
        clean_ask  = 1'b0;
        pc_we      = 1'b0;
        timed_out  = 1'b0;
        unique case (state)
            IDLE: begin
                if (trig) begin
                    next_state = FETCH;
                    la_ta_ask  = 1'b1;
                    clean_ask  = 1'b1;
                end
            end
            FETCH: begin
                la_ta_ask = 1'b1;
                clean_ask = 1'b1;
                // A completion in the timeout cycle still counts as success.
                if (ram.isCplt) begin
                    next_state = LOAD;
                end else if (timer == TMR_LAST) begin
                    next_state = LOAD;
                    timed_out  = 1'b1;
                end
            end
            LOAD: begin
                la_ta_ask  = 1'b1;
                clean_ask  = 1'b1;
                pc_we      = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_req_q       <= '0;
            pending         <= '0;
            ipc_w           <= '0;
            pc_w            <= '0;
            active_num      <= '0;
            vec_fault       <= 1'b0;
            timer           <= '0;
            ram.ram_add_bus <= '0;
            ram.ram_size    <= '0;
            ram.ram_rw      <= '0;
            ram.get_ram_ask <= 1'b0;
        end else begin
            ext_req_q <= ext_req;
            // A new edge on the line being accepted must not be lost.
            pending   <= (pending & ~accept_clr) | (ext_req & ~ext_req_q);
            vec_fault <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (trig) begin
                        ipc_w           <= resume_add;
                        active_num      <= sel_num;
                        ram.ram_add_bus <= VEC_BASE + {22'd0, sel_num, 2'b00};
                        ram.ram_size    <= 2'd3;
                        ram.ram_rw      <= 2'b10;
                        ram.get_ram_ask <= 1'b1;
                        timer           <= '0;
                    end
                end
                FETCH: begin
                    if (ram.isCplt || timed_out) begin
                        pc_w            <= ram.isCplt ? ram.ram_data_bus_read : FAULT_PC;
                        vec_fault       <= timed_out;
                        ram.ram_add_bus <= '0;
                        ram.ram_size    <= '0;
                        ram.ram_rw      <= '0;
                        ram.get_ram_ask <= 1'b0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_vector_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_vector_ctrl
// Self-checking bench for int_vector_ctrl (N_EXT=8). Each service expected by
// a test is pushed to a scoreboard queue when the stimulus is applied and
// popped when the controller strobes pc_we. A RAM responder answers vector
// reads after a programmable number of FETCH cycles (or never).
// -----------------------------------------------------------------------------
module tb_int_vector_ctrl;

    localparam int N_EXT = 8;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  num;
        logic [31:0] ipc;
        logic [31:0] pc;
        logic        fault;
        int          lat;
        int          fetch_n;
    } svc_t;

    logic              clk;
    logic              rst_n;
    logic [N_EXT-1:0]  ext_req;
    logic [N_EXT-1:0]  ext_mask;
    logic              int_sign_internal;
    logic [7:0]        int_num_internal;
    logic [31:0]       sys;
    logic [31:0]       p1_add, p2_add, p3_add, p4_add, pc;
    logic              p1_run, p2_run, p3_run;
    logic              la_ta_ask, clean_ask, pc_we, vec_fault;
    logic [31:0]       ipc_w, pc_w;
    logic [N_EXT-1:0]  pending;
    logic [7:0]        active_num;

    int_vector_ctrl_if ram ();

    int_vector_ctrl #(
        .N_EXT        (N_EXT),
        .EXT_NUM_BASE (8'h10),
        .VEC_BASE     (32'h0000_0000),
        .TIMEOUT      (16),
        .FAULT_PC     (32'h0000_0004)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ext_req           (ext_req),
        .ext_mask          (ext_mask),
        .int_sign_internal (int_sign_internal),
        .int_num_internal  (int_num_internal),
        .sys               (sys),
        .p1_add            (p1_add),
        .p2_add            (p2_add),
        .p3_add            (p3_add),
        .p4_add            (p4_add),
        .pc                (pc),
        .p1_run            (p1_run),
        .p2_run            (p2_run),
        .p3_run            (p3_run),
        .la_ta_ask         (la_ta_ask),
        .clean_ask         (clean_ask),
        .ipc_w             (ipc_w),
        .pc_w              (pc_w),
        .pc_we             (pc_we),
        .pending           (pending),
        .active_num        (active_num),
        .vec_fault         (vec_fault),
        .ram               (ram.master)
    );

    int          errors = 0;
    int          checks = 0;
    svc_t        exp_q[$];
    int          cplt_delay = 0;
    logic [31:0] vec_table [logic [31:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM responder: isCplt is driven on the falling edge so the DUT samples
    // it on the following rising edge; delay counts FETCH cycles from 0.
    initial begin
        int cnt;
        cnt = 0;
        ram.isCplt = 1'b0;
        ram.ram_data_bus_read = '0;
        forever begin
            @(negedge clk);
            if (ram.get_ram_ask) begin
                if (cnt == cplt_delay) begin
                    ram.isCplt = 1'b1;
                    ram.ram_data_bus_read = vec_table.exists(ram.ram_add_bus)
                                          ? vec_table[ram.ram_add_bus]
                                          : (32'hDEAD_0000 | ram.ram_add_bus);
                end else begin
                    ram.isCplt = 1'b0;
                end
                cnt++;
            end else begin
                cnt = 0;
                ram.isCplt = 1'b0;
            end
        end
    end

    task automatic push_exp(input logic [31:0] addr, input logic [7:0] num,
                            input logic [31:0] ipc, input logic [31:0] npc,
                            input logic fault, input int lat, input int fetch_n);
        svc_t e;
        e.addr = addr; e.num = num; e.ipc = ipc; e.pc = npc;
        e.fault = fault; e.lat = lat; e.fetch_n = fetch_n;
        exp_q.push_back(e);
    endtask

    // Follows one service from the current point until pc_we, then compares
    // everything observed against the oldest scoreboard entry.
    task automatic run_service(input string name);
        svc_t        e;
        int          n = 0;
        int          fetch_n = 0;
        bit          got = 0;
        bit          done = 0;
        logic [31:0] cap_addr = '0;
        logic [31:0] cap_ipc = '0;
        logic [7:0]  cap_num = '0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            if (ram.get_ram_ask) begin
                fetch_n++;
                if (!got) begin
                    got = 1;
                    cap_addr = ram.ram_add_bus;
                    cap_num  = active_num;
                    cap_ipc  = ipc_w;
                    // The handler side would retire the exception request.
                    int_sign_internal = 1'b0;
                    checks++;
                    if ({ram.ram_rw, ram.ram_size, la_ta_ask, clean_ask} !== 6'b10_11_1_1) begin
                        errors++;
                        $display("FAIL %s fetch_ctrl: rw/size/la/clean=%b required 101111", name,
                                 {ram.ram_rw, ram.ram_size, la_ta_ask, clean_ask});
                    end
                end
            end
            if (pc_we) done = 1;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: no expected entry", name);
            return;
        end
        e = exp_q.pop_front();
        if (!done) begin
            errors++;
            $display("FAIL %s pc_we_timeout: no pc_we within %0d cycles", name, n);
            return;
        end
        checks++;
        if (cap_addr !== e.addr) begin
            errors++;
            $display("FAIL %s ram_add_bus: got %h required %h", name, cap_addr, e.addr);
        end
        checks++;
        if (cap_num !== e.num) begin
            errors++;
            $display("FAIL %s active_num: got %h required %h", name, cap_num, e.num);
        end
        checks++;
        if (cap_ipc !== e.ipc) begin
            errors++;
            $display("FAIL %s ipc_w: got %h required %h", name, cap_ipc, e.ipc);
        end
        checks++;
        if (pc_w !== e.pc) begin
            errors++;
            $display("FAIL %s pc_w: got %h required %h", name, pc_w, e.pc);
        end
        checks++;
        if (vec_fault !== e.fault) begin
            errors++;
            $display("FAIL %s vec_fault: got %b required %b", name, vec_fault, e.fault);
        end
        checks++;
        if (n !== e.lat || fetch_n !== e.fetch_n) begin
            errors++;
            $display("FAIL %s timing: latency %0d fetch %0d required %0d / %0d",
                     name, n, fetch_n, e.lat, e.fetch_n);
        end
        checks++;
        if (ram.get_ram_ask !== 1'b0 || ram.ram_rw !== 2'b00) begin
            errors++;
            $display("FAIL %s ram_release: ask=%b rw=%b required 0/00", name,
                     ram.get_ram_ask, ram.ram_rw);
        end
        @(negedge clk);
        checks++;
        if (pc_we !== 1'b0 || vec_fault !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse_width: pc_we=%b vec_fault=%b required 0/0", name,
                     pc_we, vec_fault);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({la_ta_ask, clean_ask, pc_we, vec_fault, ram.get_ram_ask} !== 5'b0) begin
            errors++;
            $display("FAIL reset_bits: got %b required 00000",
                     {la_ta_ask, clean_ask, pc_we, vec_fault, ram.get_ram_ask});
        end
        checks++;
        if ({ipc_w, pc_w, ram.ram_add_bus} !== 96'b0 || {ram.ram_rw, ram.ram_size} !== 4'b0) begin
            errors++;
            $display("FAIL reset_regs: ipc=%h pc_w=%h addr=%h rw/size=%b required 0",
                     ipc_w, pc_w, ram.ram_add_bus, {ram.ram_rw, ram.ram_size});
        end
        checks++;
        if (pending !== 8'h00 || active_num !== 8'h00) begin
            errors++;
            $display("FAIL reset_status: pending=%h active_num=%h required 00/00",
                     pending, active_num);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        sys = 32'h1;
        p1_run = 0; p2_run = 0; p3_run = 0; pc = 32'h0000_0100;
        ext_req[3] = 1'b1;
        push_exp(32'h4C, 8'h13, 32'h100, 32'h1200, 1'b0, 3, 1);
        run_service("single");
        checks++;
        if (pending !== 8'h00) begin
            errors++;
            $display("FAIL single pending: got %h required 00", pending);
        end
        ext_req = '0;
        @(negedge clk);
    endtask

    task automatic test_priority();
        ext_req[5] = 1'b1;
        ext_req[2] = 1'b1;
        push_exp(32'h48, 8'h12, 32'h100, 32'h2200, 1'b0, 3, 1);
        run_service("prio_line2");
        sys = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (pending !== 8'h20 || ram.get_ram_ask !== 1'b0 || la_ta_ask !== 1'b0) begin
            errors++;
            $display("FAIL prio_hold: pending=%h ask=%b la=%b required 20/0/0",
                     pending, ram.get_ram_ask, la_ta_ask);
        end
        sys = 32'h1;
        push_exp(32'h54, 8'h15, 32'h100, 32'h5500, 1'b0, 2, 1);
        run_service("prio_line5");
        ext_req = '0;
        @(negedge clk);
    endtask

    task automatic test_int_ext();
        p4_add = 32'h0000_0A10;
        p3_add = 32'h0000_0999;
        p3_run = 1'b1;
        ext_req[0] = 1'b1;
        @(negedge clk);
        int_sign_internal = 1'b1;
        int_num_internal  = 8'h02;
        push_exp(32'h40, 8'h10, 32'h0A10, 32'h1000, 1'b0, 2, 1);
        run_service("int_plus_ext");
        ext_req = '0;
        p3_run = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_resume();
        p1_run = 1'b1; p1_add = 32'h0000_0A00;
        p2_run = 1'b1; p2_add = 32'h0000_0B00;
        p3_run = 1'b0;
        int_sign_internal = 1'b1;
        int_num_internal  = 8'h02;
        push_exp(32'h08, 8'h02, 32'h0B00, 32'h3000, 1'b0, 2, 1);
        run_service("resume_p2");
        p1_run = 1'b0; p2_run = 1'b0;
        pc = 32'h0000_0C00;
        int_sign_internal = 1'b1;
        int_num_internal  = 8'h05;
        push_exp(32'h14, 8'h05, 32'h0C00, 32'h3400, 1'b0, 2, 1);
        run_service("resume_pc");
    endtask

    task automatic test_timeout();
        cplt_delay = -1;
        int_sign_internal = 1'b1;
        int_num_internal  = 8'h07;
        push_exp(32'h1C, 8'h07, 32'h0C00, 32'h0000_0004, 1'b1, 17, 16);
        run_service("timeout");
        // Completion on the last allowed cycle must beat the timeout.
        cplt_delay = 15;
        int_sign_internal = 1'b1;
        int_num_internal  = 8'h06;
        push_exp(32'h18, 8'h06, 32'h0C00, 32'h6000, 1'b0, 17, 16);
        run_service("cplt_at_limit");
        cplt_delay = 0;
    endtask

    task automatic test_mask_disable();
        ext_mask = 8'hFD;
        ext_req[1] = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (pending !== 8'h02 || ram.get_ram_ask !== 1'b0 || la_ta_ask !== 1'b0) begin
            errors++;
            $display("FAIL masked_hold: pending=%h ask=%b la=%b required 02/0/0",
                     pending, ram.get_ram_ask, la_ta_ask);
        end
        ext_mask = 8'hFF;
        push_exp(32'h44, 8'h11, 32'h0C00, 32'h4400, 1'b0, 2, 1);
        run_service("unmasked");
        ext_req = '0;
        sys = 32'h0;
        @(negedge clk);
        ext_req[4] = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (pending !== 8'h10 || ram.get_ram_ask !== 1'b0 || la_ta_ask !== 1'b0) begin
            errors++;
            $display("FAIL disabled_hold: pending=%h ask=%b la=%b required 10/0/0",
                     pending, ram.get_ram_ask, la_ta_ask);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int n = 0;
        cplt_delay = -1;
        sys = 32'h1;
        while (ram.get_ram_ask !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ram.get_ram_ask !== 1'b1 || ram.ram_add_bus !== 32'h50) begin
            errors++;
            $display("FAIL midfetch_start: ask=%b addr=%h required 1/00000050",
                     ram.get_ram_ask, ram.ram_add_bus);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ram.get_ram_ask !== 1'b0 || ram.ram_rw !== 2'b00 || pending !== 8'h00
            || la_ta_ask !== 1'b0 || ram.ram_add_bus !== 32'h0 || active_num !== 8'h00) begin
            errors++;
            $display("FAIL midfetch_reset: ask=%b rw=%b pending=%h la=%b addr=%h num=%h required 0",
                     ram.get_ram_ask, ram.ram_rw, pending, la_ta_ask, ram.ram_add_bus, active_num);
        end
        ext_req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cplt_delay = 0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        ext_req = '0;
        ext_mask = 8'hFF;
        int_sign_internal = 1'b0;
        int_num_internal = 8'h00;
        sys = 32'h0;
        p1_add = '0; p2_add = '0; p3_add = '0; p4_add = '0; pc = '0;
        p1_run = 1'b0; p2_run = 1'b0; p3_run = 1'b0;
        vec_table[32'h4C] = 32'h0000_1200;
        vec_table[32'h48] = 32'h0000_2200;
        vec_table[32'h54] = 32'h0000_5500;
        vec_table[32'h40] = 32'h0000_1000;
        vec_table[32'h08] = 32'h0000_3000;
        vec_table[32'h14] = 32'h0000_3400;
        vec_table[32'h18] = 32'h0000_6000;
        vec_table[32'h44] = 32'h0000_4400;
        vec_table[32'h50] = 32'h0000_5000;

        test_reset();
        test_single();
        test_priority();
        test_int_ext();
        test_resume();
        test_timeout();
        test_mask_disable();
        test_reset_mid_fetch();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int_vector_ctrl.md
Name: int_vector_ctrl

Overview:
Parametrised successor of the single-source interrupt core. It latches N_EXT edge-triggered external requests plus one internal request, selects one by fixed priority and freezes the pipeline. It saves the resume address to ipc, fetches the handler address from a relocatable vector table over the shared RAM port (with timeout), and loads pc. It sits beside the pipeline and arbitrates RAM ownership with the execute stage through get_ram_ask.

Parameters:
N_EXT, 8, number of external interrupt lines (1..32)
EXT_NUM_BASE, 8'h10, interrupt number of ext line 0; line i uses EXT_NUM_BASE+i
VEC_BASE, 32'h0000_0000, byte base address of the vector table
TIMEOUT, 16, max cycles waiting for isCplt before vector fault
FAULT_PC, 32'h0000_0004, pc loaded on vector fetch timeout

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ext_req  in  N_EXT  external request lines, rising-edge sensitive
ext_mask  in  N_EXT  1 = line enabled
int_sign_internal  in  1  internal (exception) request, level
int_num_internal  in  8  internal interrupt number
sys  in  32  status register; sys[0] = global interrupt enable
p1_add,p2_add,p3_add,p4_add,pc  in  32 each  pipeline stage addresses
p1_run,p2_run,p3_run  in  1 each  stage valid flags
la_ta_ask  out  1  force r0 privilege, clear sys[0], write ipc
clean_ask  out  1  flush pipeline
ipc_w  out  32  resume address
pc_w  out  32  handler address
pc_we  out  1  one-cycle pc write strobe
ram_add_bus  out  32  vector address
ram_size  out  2  3 = word
ram_rw  out  2  00 idle, 10 read
ram_data_bus_read  in  32  read data
isCplt  in  1  RAM completion
get_ram_ask  out  1  request RAM port ownership
pending  out  N_EXT  latched external requests (debug/status)
active_num  out  8  number of the interrupt being serviced
vec_fault  out  1  one-cycle pulse on fetch timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE; pending, ext_req_q, ipc_w, pc_w, ram_add_bus, ram_rw, ram_size, active_num, timer = 0; all single-bit outputs 0.
- Edge latch: every cycle ext_req_q <= ext_req. Set pending[i] when ext_req[i] & ~ext_req_q[i]. Pending persists through masking and sys[0]=0. Clear pending[i] only on acceptance of line i. When set and clear coincide on the same line, set wins.
- Eligible external set = pending & ext_mask. Winner = lowest index.
- Trigger (combinational, IDLE only): trig = sys[0] & (int_sign_internal | any eligible).
- la_ta_ask = clean_ask = trig in IDLE, and 1 throughout FETCH and LOAD.
- Resume address (ipc):
  - external and internal both present: p4_add. External is serviced; the faulting instruction re-executes.
  - otherwise: first of p3_add, p2_add, p1_add whose run flag is set, else pc.
- Source selection: external beats internal. active_num = EXT_NUM_BASE + winner index, else int_num_internal.
- States:
  - IDLE -> FETCH on trig:
    - ipc_w <= resume address
    - ram_add_bus <= VEC_BASE + (active_num << 2), using 32-bit wraparound add
    - ram_size <= 3, ram_rw <= 2'b10, get_ram_ask <= 1, timer <= 0
    - clear the accepted pending bit
  - FETCH, isCplt=1 -> LOAD: pc_w <= ram_data_bus_read; ram_rw, ram_size, ram_add_bus <= 0; get_ram_ask <= 0.
  - FETCH, timer == TIMEOUT-1 without isCplt -> LOAD: pc_w <= FAULT_PC; vec_fault pulses; RAM outputs released as above. When isCplt arrives in the same cycle as the timeout, isCplt wins.
  - LOAD -> IDLE: pc_we = 1 for exactly this cycle.
- Latency: trigger edge to pc_we = 2 + (cycles until isCplt) clocks. With isCplt on the first FETCH cycle, pc_we asserts 2 cycles after the trigger edge.
- Requests arriving during FETCH/LOAD only set pending; they are never lost. A new trigger is evaluated in IDLE on the cycle after LOAD (minimum 1 idle cycle between services, since sys[0] is cleared by la_ta_ask).
- rst_n asserted mid-FETCH: immediately releases RAM (get_ram_ask=0, ram_rw=0); pending cleared.
- N_EXT=1 must elaborate; index widths use $clog2 with a minimum of 1.

Test Plan:
- Single external: N_EXT=8, EXT_NUM_BASE=8'h10, sys[0]=1, rising edge on ext_req[3], isCplt next cycle with data 32'h0000_1200 -> ram_add_bus=32'h0000_004C, active_num=8'h13, pc_w=32'h1200, pc_we one cycle, pending[3] cleared.
- Priority: edges on ext_req[5] and ext_req[2] in the same cycle -> line 2 serviced first (addr 32'h48). After the return, with sys[0] re-set, line 5 is serviced (addr 32'h54).
- Simultaneous internal + external: int_sign_internal=1, num 8'h02, plus ext_req[0] edge, p4_add=32'h0000_0A10 -> ipc_w=32'h0A10, active_num=8'h10.
- Resume selection: internal only, p3_run=0, p2_run=1, p2_add=32'h0000_0B00 -> ipc_w=32'h0B00. With all run flags 0 and pc=32'h0C00 -> ipc_w=32'h0C00.
- Timeout: isCplt held 0 -> after 16 FETCH cycles vec_fault pulses, pc_w=32'h0000_0004, pc_we asserts, get_ram_ask drops.
- Masked and disabled lines: ext_mask[1]=0 with an edge on line 1 -> no trigger, pending[1]=1. Setting the mask bit then fires the line. With sys[0]=0, nothing fires. Async reset mid-FETCH -> all outputs 0 immediately.
